// File: rtl/time_uart_reporter.sv
// Time-of-day reporter: snapshots hours/minutes and streams "HH:MM[\r\n]" as ASCII
// into a byte-wide UART transmitter using its start/ready handshake.
module time_uart_reporter #(
    parameter bit          AutoReport = 1'b1,
    parameter bit          AppendCrLf = 1'b1,
    parameter logic [7:0]  Separator  = 8'h3A,
    parameter int unsigned AckTimeout = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] minutes,
    input  logic [5:0] hours,
    input  logic       reportRequest,
    input  logic       uartReady,
    output logic       startTransmission,
    output logic [7:0] dataBits,
    output logic       busy,
    output logic       messageDone,
    output logic       error
);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StLoad      = 3'd1;
    localparam logic [2:0] StWaitReady = 3'd2;
    localparam logic [2:0] StWaitAck   = 3'd3;
    localparam logic [2:0] StWaitDone  = 3'd4;

    localparam logic [2:0]  LastIndex = AppendCrLf ? 3'd6 : 3'd4;
    localparam int unsigned CntW      = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(AckTimeout - 1);

    logic [2:0]      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic [5:0]      prev_min_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     hours_ascii_q, hours_ascii_d;
    logic [15:0]     min_ascii_q, min_ascii_d;
    logic            start_q, start_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            trig;
    logic [7:0]      cur_byte;

    // Binary 0..63 to two ASCII digits; tens saturates naturally at 6.
    function automatic logic [15:0] to_ascii(input logic [5:0] value);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = value;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {8'h30 + {4'h0, tens}, 8'h30 + {2'b00, rem}};
    endfunction

    assign trig = reportRequest | (AutoReport & (minutes != prev_min_q));

    always_comb begin
        cur_byte = 8'h0A;
        case (idx_q)
            3'd0:    cur_byte = hours_ascii_q[15:8];
            3'd1:    cur_byte = hours_ascii_q[7:0];
            3'd2:    cur_byte = Separator;
            3'd3:    cur_byte = min_ascii_q[15:8];
            3'd4:    cur_byte = min_ascii_q[7:0];
            3'd5:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pending_d     = pending_q | (trig & (state_q != StIdle));
        cnt_d         = cnt_q;
        hours_ascii_d = hours_ascii_q;
        min_ascii_d   = min_ascii_q;
        start_d       = 1'b0;
        data_d        = data_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig || pending_q) begin
                    state_d   = StLoad;
                    pending_d = 1'b0;
                end
            end
            StLoad: begin
                hours_ascii_d = to_ascii(hours);
                min_ascii_d   = to_ascii(minutes);
                state_d       = StWaitReady;
            end
            StWaitReady: begin
                if (uartReady) begin
                    data_d  = cur_byte;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (!uartReady) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntMax) begin
                    // Transmitter never took the byte: abandon the message.
                    error_d = 1'b1;
                    idx_d   = 3'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (uartReady) begin
                    if (idx_q == LastIndex) begin
                        done_d  = 1'b1;
                        idx_d   = 3'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StWaitReady;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= 3'd0;
            pending_q     <= 1'b0;
            prev_min_q    <= minutes;
            cnt_q         <= '0;
            hours_ascii_q <= 16'h0000;
            min_ascii_q   <= 16'h0000;
            start_q       <= 1'b0;
            data_q        <= 8'h00;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            prev_min_q    <= minutes;
            cnt_q         <= cnt_d;
            hours_ascii_q <= hours_ascii_d;
            min_ascii_q   <= min_ascii_d;
            start_q       <= start_d;
            data_q        <= data_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign startTransmission = start_q;
    assign dataBits          = data_q;
    assign busy              = (state_q != StIdle);
    assign messageDone       = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_time_uart_reporter.sv
// Bench for time_uart_reporter: two instances (CR/LF + auto report, and 5-byte manual),
// a transmitter model per instance and an expected-byte scoreboard.
module tb_time_uart_reporter;

    localparam int unsigned AckTimeout = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] minutes [2];
    logic [5:0] hours   [2];
    logic       req     [2];
    logic       ready   [2];
    logic       start   [2];
    logic [7:0] data    [2];
    logic       busy    [2];
    logic       done    [2];
    logic       err     [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [2][$];
    logic [7:0] log_q [2][$];
    int start_cnt [2];
    int done_cnt  [2];
    int err_cnt   [2];
    int tx_mode   [2];
    int s0, d0, e0, n, k;

    always #5 clock = ~clock;

    time_uart_reporter #(
        .AutoReport(1'b1), .AppendCrLf(1'b1), .Separator(8'h3A), .AckTimeout(AckTimeout)
    ) dut0 (
        .clock(clock), .reset(reset), .minutes(minutes[0]), .hours(hours[0]),
        .reportRequest(req[0]), .uartReady(ready[0]), .startTransmission(start[0]),
        .dataBits(data[0]), .busy(busy[0]), .messageDone(done[0]), .error(err[0])
    );

    time_uart_reporter #(
        .AutoReport(1'b0), .AppendCrLf(1'b0), .Separator(8'h3A), .AckTimeout(AckTimeout)
    ) dut1 (
        .clock(clock), .reset(reset), .minutes(minutes[1]), .hours(hours[1]),
        .reportRequest(req[1]), .uartReady(ready[1]), .startTransmission(start[1]),
        .dataBits(data[1]), .busy(busy[1]), .messageDone(done[1]), .error(err[1])
    );

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic cycles(input int cnt);
        repeat (cnt) @(negedge clock);
    endtask

    task automatic pulse_req(input int g);
        req[g] = 1'b1;
        @(negedge clock);
        req[g] = 1'b0;
    endtask

    // Reference message: decimal digits of the snapshot as ASCII.
    task automatic expect_msg(input int g, input int h, input int m);
        exp_q[g].push_back(8'h30 + 8'(h / 10));
        exp_q[g].push_back(8'h30 + 8'(h % 10));
        exp_q[g].push_back(8'h3A);
        exp_q[g].push_back(8'h30 + 8'(m / 10));
        exp_q[g].push_back(8'h30 + 8'(m % 10));
        if (g == 0) begin
            exp_q[g].push_back(8'h0D);
            exp_q[g].push_back(8'h0A);
        end
    endtask

    task automatic wait_done(input int g, input int budget, input string name);
        int c;
        c = 0;
        while (!done[g] && c < budget) begin
            @(negedge clock);
            c++;
        end
        checks++;
        if (!done[g]) begin
            failures++;
            $display("FAIL %s: no messageDone within %0d cycles", name, budget);
        end
    endtask

    // want holds cnt bytes, first byte in the most significant position.
    task automatic check_log(input int g, input string name, input logic [55:0] want,
                             input int cnt);
        check({name, "_len"}, log_q[g].size(), cnt);
        for (int i = 0; i < cnt && i < log_q[g].size(); i++) begin
            check(name, log_q[g][i], want[8*(cnt-1-i) +: 8]);
        end
    endtask

    task automatic monitor(input int g);
        int         in_msg;
        int         msg_len;
        logic       prev_start, prev_done, prev_err;
        logic [7:0] e;
        in_msg     = 0;
        msg_len    = (g == 0) ? 7 : 5;
        prev_start = 1'b0;
        prev_done  = 1'b0;
        prev_err   = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_msg     = 0;
                prev_start = 1'b0;
                prev_done  = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (start[g]) begin
                    start_cnt[g]++;
                    in_msg++;
                    log_q[g].push_back(data[g]);
                    check("start_while_busy", busy[g], 1);
                    check("start_one_cycle", prev_start, 0);
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_start: got byte 0x%0h, expected no start",
                                 data[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        check("byte", data[g], e);
                    end
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    check("done_msg_len", in_msg, msg_len);
                    check("done_busy_low", busy[g], 0);
                    check("done_one_cycle", prev_done, 0);
                    in_msg = 0;
                end
                if (err[g]) begin
                    err_cnt[g]++;
                    check("err_one_cycle", prev_err, 0);
                    in_msg = 0;
                end
                prev_start = start[g];
                prev_done  = done[g];
                prev_err   = err[g];
            end
        end
    endtask

    // Transmitter: ready falls 3 cycles after a start and rises 20 cycles after it.
    task automatic tx_model(input int g);
        logic [7:0] held;
        bit         abort;
        ready[g] = 1'b1;
        forever begin
            @(negedge clock);
            if (tx_mode[g] == 0 && !reset && start[g] && ready[g]) begin
                held  = data[g];
                abort = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    if (reset) abort = 1'b1;
                    if (!abort) check("data_hold", data[g], held);
                end
                ready[g] = 1'b0;
                repeat (17) @(negedge clock);
                ready[g] = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            req[g] = 1'b0; tx_mode[g] = 0; start_cnt[g] = 0; done_cnt[g] = 0; err_cnt[g] = 0;
        end
        hours[0] = 6'd13; minutes[0] = 6'd42; hours[1] = 6'd0; minutes[1] = 6'd0;
        fork
            monitor(0); monitor(1); tx_model(0); tx_model(1);
        join_none
        cycles(3);
        check("rst_start", start[0], 0);
        check("rst_data", data[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_err", err[0], 0);
        reset = 1'b0;
        cycles(12);
        check("release_no_msg", start_cnt[0], 0);
        check("release_busy", busy[0], 0);

        // Request-driven message 13:07 with earliest-start latency.
        reset = 1'b1; minutes[0] = 6'd7; cycles(2); reset = 1'b0; cycles(2);
        log_q[0].delete(); s0 = start_cnt[0]; d0 = done_cnt[0];
        expect_msg(0, 13, 7);
        pulse_req(0);
        check("lat_busy_k1", busy[0], 1);
        check("lat_start_k1", start[0], 0);
        cycles(1); check("lat_start_k2", start[0], 0);
        cycles(1); check("lat_start_k3", start[0], 1);
        wait_done(0, 400, "t1_done");
        cycles(3);
        check_log(0, "t1_bytes", 56'h3133_3A30_370D_0A, 7);
        check("t1_starts", start_cnt[0] - s0, 7);
        check("t1_dones", done_cnt[0] - d0, 1);
        check("t1_busy_after", busy[0], 0);

        // Auto report on 23:59 -> 00:00.
        reset = 1'b1; hours[0] = 6'd23; minutes[0] = 6'd59; cycles(2); reset = 1'b0; cycles(5);
        log_q[0].delete(); s0 = start_cnt[0]; d0 = done_cnt[0];
        expect_msg(0, 0, 0);
        hours[0] = 6'd0; minutes[0] = 6'd0;
        wait_done(0, 400, "t2_done");
        cycles(30);
        check_log(0, "t2_bytes", 56'h3030_3A30_300D_0A, 7);
        check("t2_starts", start_cnt[0] - s0, 7);
        check("t2_dones", done_cnt[0] - d0, 1);

        // Three requests during a message collapse into one follow-up.
        s0 = start_cnt[0]; d0 = done_cnt[0];
        expect_msg(0, 0, 0); expect_msg(0, 0, 0);
        pulse_req(0); cycles(30);
        repeat (3) begin pulse_req(0); cycles(5); end
        wait_done(0, 400, "t3_done1");
        check("t3_idle_gap", busy[0], 0);
        cycles(1); check("t3_rebusy", busy[0], 1);
        wait_done(0, 400, "t3_done2");
        cycles(40);
        check("t3_starts", start_cnt[0] - s0, 14);
        check("t3_dones", done_cnt[0] - d0, 2);

        // Transmitter never acknowledges.
        tx_mode[0] = 1; s0 = start_cnt[0]; e0 = err_cnt[0];
        exp_q[0].push_back(8'h30);
        pulse_req(0);
        n = 0;
        while (!start[0] && n < 20) begin cycles(1); n++; end
        check("t4_first_start", start[0], 1);
        n = 0;
        while (!err[0] && n < 100) begin cycles(1); n++; end
        check("t4_err_delay", n, AckTimeout);
        check("t4_err_busy", busy[0], 0);
        cycles(1); check("t4_err_pulse", err[0], 0);
        cycles(40);
        check("t4_starts", start_cnt[0] - s0, 1);
        check("t4_errs", err_cnt[0] - e0, 1);
        tx_mode[0] = 0;

        // Reset after the third byte starts; the next message restarts at byte 0.
        expect_msg(0, 0, 0);
        pulse_req(0);
        k = 0; n = 0;
        while (k < 3 && n < 300) begin cycles(1); n++; if (start[0]) k++; end
        check("t5_third_start", k, 3);
        reset = 1'b1; hours[0] = 6'd13; minutes[0] = 6'd7;
        cycles(1);
        check("t5_rst_start", start[0], 0);
        check("t5_rst_data", data[0], 0);
        check("t5_rst_busy", busy[0], 0);
        check("t5_rst_done", done[0], 0);
        check("t5_rst_err", err[0], 0);
        cycles(1); reset = 1'b0;
        exp_q[0].delete();
        cycles(30);
        log_q[0].delete(); s0 = start_cnt[0];
        expect_msg(0, 13, 7);
        pulse_req(0);
        wait_done(0, 400, "t5_done");
        cycles(3);
        check_log(0, "t5_bytes", 56'h3133_3A30_370D_0A, 7);
        check("t5_starts", start_cnt[0] - s0, 7);

        // Five-byte instance with out-of-range time 63:60.
        hours[1] = 6'd63; minutes[1] = 6'd60; cycles(3);
        check("t6_no_auto", busy[1], 0);
        log_q[1].delete(); s0 = start_cnt[1];
        expect_msg(1, 63, 60);
        pulse_req(1);
        wait_done(1, 300, "t6_done");
        cycles(3);
        check_log(1, "t6_bytes", 56'h36_333A_3630, 5);
        check("t6_starts", start_cnt[1] - s0, 5);

        check("exp_drained0", exp_q[0].size(), 0);
        check("exp_drained1", exp_q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
